// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants and counter type for the VGA sync generator.
package vga_timing_pkg;

   localparam int unsigned CNT_W = 10;
   typedef logic [CNT_W-1:0] cnt_t;

   // Horizontal timing in pixels.
   localparam int unsigned H_ACTIVE_640 = 640;
   localparam int unsigned H_FP_640     = 16;
   localparam int unsigned H_SYNC_640   = 96;
   localparam int unsigned H_BP_640     = 48;
   localparam int unsigned H_TOTAL_640  = H_ACTIVE_640 + H_FP_640 + H_SYNC_640 + H_BP_640;

   // Vertical timing in lines.
   localparam int unsigned V_ACTIVE_480 = 480;
   localparam int unsigned V_FP_480     = 10;
   localparam int unsigned V_SYNC_480   = 2;
   localparam int unsigned V_BP_480     = 33;
   localparam int unsigned V_TOTAL_480  = V_ACTIVE_480 + V_FP_480 + V_SYNC_480 + V_BP_480;

   // Half-open window test: lo <= val < hi.
   function automatic logic in_window(cnt_t val, cnt_t lo, cnt_t hi);
      return (val >= lo) && (val < hi);
   endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bus: pixel enable into the generator, sync/video/position out of it.
interface vga_sync_gen_if;
   import vga_timing_pkg::*;

   logic pix_tick;
   logic hsync;
   logic vsync;
   logic video_on;
   cnt_t x;
   cnt_t y;
   logic frame_start;

   // The sync generator drives the timing outputs.
   modport master (
      input  pix_tick,
      output hsync,
      output vsync,
      output video_on,
      output x,
      output y,
      output frame_start
   );

   // Pixel pipeline: supplies the tick, consumes timing.
   modport slave (
      output pix_tick,
      input  hsync,
      input  vsync,
      input  video_on,
      input  x,
      input  y,
      input  frame_start
   );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap, registered sync window and active flag.
// Decode registers are fed from the next count so they never lag the counter.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned ACTIVE   = H_ACTIVE_640,
   parameter int unsigned FP       = H_FP_640,
   parameter int unsigned SYNC     = H_SYNC_640,
   parameter int unsigned BP       = H_BP_640,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,    // pixel enable: refresh decode
   input  logic inc,     // advance count; only ever high together with tick
   output cnt_t cnt,
   output logic wrap,    // inc on the last position
   output logic sync,
   output logic active
);

   localparam int unsigned TOTAL   = ACTIVE + FP + SYNC + BP;
   localparam cnt_t        LAST    = cnt_t'(TOTAL - 1);
   localparam cnt_t        SYNC_LO = cnt_t'(ACTIVE + FP);
   localparam cnt_t        SYNC_HI = cnt_t'(ACTIVE + FP + SYNC);
   localparam cnt_t        ACT_END = cnt_t'(ACTIVE);

   cnt_t cnt_q, cnt_d;
   logic sync_q, sync_d;
   logic active_q, active_d;

   assign wrap = inc && (cnt_q == LAST);

   // Next count and its decode.
   always_comb begin
      cnt_d = cnt_q;
      if (inc) begin
         cnt_d = wrap ? '0 : cnt_q + 1'b1;
      end
      sync_d   = in_window(cnt_d, SYNC_LO, SYNC_HI) ? SYNC_POL : ~SYNC_POL;
      active_d = (cnt_d < ACT_END);
   end

   // Counter and decode state; everything holds between ticks.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         sync_q   <= ~SYNC_POL;
         active_q <= 1'b0;
      end else if (tick) begin
         cnt_q    <= cnt_d;
         sync_q   <= sync_d;
         active_q <= active_d;
      end
   end

   assign cnt    = cnt_q;
   assign sync   = sync_q;
   assign active = active_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: horizontal and vertical axis counters with registered
// sync/video decode. Optional frame_start pulse enabled by VGA_SYNC_FRAME_PULSE_EN.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_640,
   parameter int unsigned H_FP     = H_FP_640,
   parameter int unsigned H_SYNC   = H_SYNC_640,
   parameter int unsigned H_BP     = H_BP_640,
   parameter int unsigned V_ACTIVE = V_ACTIVE_480,
   parameter int unsigned V_FP     = V_FP_480,
   parameter int unsigned V_SYNC   = V_SYNC_480,
   parameter int unsigned V_BP     = V_BP_480,
   parameter bit          SYNC_POL = 1'b0
) (
   input logic            clk,
   input logic            rst_n,
   vga_sync_gen_if.master vga
);

   cnt_t h_cnt, v_cnt;
   logic h_wrap, v_wrap;
   logic h_sync, v_sync;
   logic h_active, v_active;

   vga_axis_counter #(
      .ACTIVE   (H_ACTIVE),
      .FP       (H_FP),
      .SYNC     (H_SYNC),
      .BP       (H_BP),
      .SYNC_POL (SYNC_POL)
   ) u_h_axis (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (vga.pix_tick),
      .inc    (vga.pix_tick),
      .cnt    (h_cnt),
      .wrap   (h_wrap),
      .sync   (h_sync),
      .active (h_active)
   );

   // Vertical decode refreshes every tick so video_on is right straight after reset.
   vga_axis_counter #(
      .ACTIVE   (V_ACTIVE),
      .FP       (V_FP),
      .SYNC     (V_SYNC),
      .BP       (V_BP),
      .SYNC_POL (SYNC_POL)
   ) u_v_axis (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (vga.pix_tick),
      .inc    (h_wrap),
      .cnt    (v_cnt),
      .wrap   (v_wrap),
      .sync   (v_sync),
      .active (v_active)
   );

   assign vga.x        = h_cnt;
   assign vga.y        = v_cnt;
   assign vga.hsync    = h_sync;
   assign vga.vsync    = v_sync;
   assign vga.video_on = h_active & v_active;

`ifdef VGA_SYNC_FRAME_PULSE_EN
   logic frame_q;

   // One-clk pulse after the tick edge that returns the raster to (0,0).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_q <= 1'b0;
      end else begin
         frame_q <= v_wrap;
      end
   end

   assign vga.frame_start = frame_q;
`else
   logic unused_v_wrap;
   assign unused_v_wrap   = v_wrap;
   assign vga.frame_start = 1'b0;
`endif

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter SYNC_POL, default 0, sync level when asserted (0 = active-low).
REQ-010 SHALL have port clk, input, 1, sole system clock; all logic on rising edge.
REQ-011 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-012 SHALL have port pix_tick, input, 1, one-clk pixel enable from the clock divider stage.
REQ-013 SHALL have port hsync, output, 1, horizontal sync.
REQ-014 SHALL have port vsync, output, 1, vertical sync.
REQ-015 SHALL have port video_on, output, 1, high inside the active region.
REQ-016 SHALL have port x, output, 10, current horizontal count.
REQ-017 SHALL have port y, output, 10, current vertical count.
REQ-018 SHALL have port frame_start, output, 1, frame-wrap pulse (see Configuration).

Function
REQ-019 SHALL keep h_cnt in 0..H_TOTAL-1 (H_TOTAL = sum of H_*, 800 by default) and v_cnt in 0..V_TOTAL-1 (525 by default), both 10 bits wide.
REQ-020 SHALL change counters only on clk edges where pix_tick=1; with pix_tick=0, all counters and outputs hold.
REQ-021 SHALL increment h_cnt on each tick, wrapping from H_TOTAL-1 to 0 and incrementing v_cnt on that wrap.
REQ-022 SHALL wrap v_cnt from V_TOTAL-1 to 0 when h_cnt wraps on line V_TOTAL-1.
REQ-023 SHALL register all outputs so that after each edge they reflect the new (h_cnt, v_cnt), i.e. zero ticks of lag between x/y and the sync/video decode.
REQ-024 SHALL drive x=h_cnt and y=v_cnt at all times.
REQ-025 SHALL assert hsync (level SYNC_POL) iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751 by default.
REQ-026 SHALL assert vsync iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491 by default.
REQ-027 SHALL drive video_on=1 iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-028 SHALL treat pix_tick held high continuously as a valid 1:1 pixel rate.

Reset
REQ-029 SHALL, on a clk edge with rst_n=0, set h_cnt=0, v_cnt=0, x=0, y=0, hsync=vsync=~SYNC_POL, video_on=0 and frame_start=0, regardless of pix_tick.
REQ-030 SHALL, after rst_n rises, resume normal decode at the first tick, which moves counters to (1,0) with video_on=1.
REQ-031 SHALL, on reset mid-frame, abandon the frame immediately with no partial sync pulse extension.

Configuration
REQ-032 SHALL, with VGA_SYNC_FRAME_PULSE_EN defined, drive frame_start high for exactly one clk cycle following the tick edge on which counters wrap to (0,0).
REQ-033 SHALL, without VGA_SYNC_FRAME_PULSE_EN, tie frame_start to 0 and omit its logic.

Structure
REQ-034 SHALL take 640x480@60 timing constants (H/V active, porches, sync, totals) from shared package vga_timing_pkg.
REQ-035 SHALL implement each axis with one sub-module, vga_axis_counter (count, wrap, sync window, active flag), instantiated twice.

Verification
REQ-036 SHALL check reset: rst_n=0 for 3 clks with pix_tick=1 -> x=0, y=0, hsync=1, vsync=1, video_on=0, frame_start=0.
REQ-037 SHALL check hsync timing: pix_tick=1 continuous after reset -> hsync=0 after tick 656, back to 1 after tick 752, and x returns to 0 after tick 800.
REQ-038 SHALL check vsync timing: continuous ticks -> vsync=0 from tick 392000 (y=490) through tick 393599, then 1.
REQ-039 SHALL check tick gating: pix_tick=0 for 20 clks at x=100 -> x=100 and all outputs unchanged.
REQ-040 SHALL check reset mid-operation: rst_n=0 at x=700, y=491 -> next edge gives x=0, y=0, hsync=1, vsync=1.
REQ-041 SHALL check the frame pulse: with VGA_SYNC_FRAME_PULSE_EN -> frame_start high for exactly one clk after tick 420000, with pix_tick=1 on alternate clks; without it -> frame_start always 0.
